me_block_scheduler: RTL and testbench
=====================================

# me_block_scheduler

Frame-level controller that sequences the motion-estimation core over every 8x8 block of a frame. It computes per-block current and reference memory base addresses, enables the core, and detects block completion from the core's `data_valid` handshake. It captures MSAD and motion vector into a small result FIFO drained by a valid/ready consumer. It sits between the host/DMA control logic and the ME top level.

## Interface
- `FRAME_W_BLOCKS`, 8: blocks per frame row (1..32).
- `FRAME_H_BLOCKS`, 8: block rows per frame (1..32).
- `CUR_BLK_BYTES`, 64: address stride between consecutive current blocks.
- `REF_BLK_BYTES`, 512: address stride between consecutive reference windows.
- `SAD_BIT_WIDTH`, 14: MSAD width.
- `RES_DEPTH`, 4: result FIFO depth (power of two).
- `TIMEOUT_CYCLES`, 1023: maximum cycles a block may stay in flight.
- `clk` in 1: the single clock. All state is updated on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame. Sampled only in IDLE.
- `frame_base_cur` in 32: current-frame base address. Latched at start.
- `frame_base_ref` in 32: reference-frame base address. Latched at start.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `timeout_err` out 1: sticky flag. Cleared by the next accepted start.
- `me_en` out 1: drives the core's `en_i`.
- `blk_cur_base` out 32: current-block base address for the core's address generator.
- `blk_ref_base` out 32: reference-block base address for the core's address generator.
- `me_data_valid` in 1: the core's `data_valid`. It is low while a block is processing.
- `me_msad` in SAD_BIT_WIDTH: core MSAD.
- `me_col` in 5: core MSAD column.
- `me_row` in 5: core MSAD row.
- `res_valid` out 1: result FIFO not empty.
- `res_ready` in 1: consumer accepts the result.
- `res_sad` out SAD_BIT_WIDTH: result MSAD.
- `res_mv_col` out 5: result motion-vector column.
- `res_mv_row` out 5: result motion-vector row.
- `res_blk_x` out 5: block column of the result.
- `res_blk_y` out 5: block row of the result.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, latch the bases, set bx=by=0, clear `timeout_err`, go to LAUNCH.
  - LAUNCH: if FIFO count < RES_DEPTH, assert `me_en`, clear the timer, go to ARM. Otherwise stall in LAUNCH with `me_en`=0.
  - ARM: `me_en`=1. Wait for `me_data_valid`=0, meaning the core has started. Then go to RUN.
  - RUN: `me_en`=1. On `me_data_valid`=1, capture `me_msad`, `me_col`, `me_row`, bx and by, push them into the FIFO, and go to NEXT.
  - NEXT: `me_en`=0. If the block was the last one (bx=FRAME_W_BLOCKS-1 and by=FRAME_H_BLOCKS-1), go to DONE. Otherwise advance to the next block and go to LAUNCH.
    - bx increments.
    - When bx wraps to 0, by increments.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic, computed from the registered bx and by, modulo 2^32, with no overflow flag:
  - idx = by*FRAME_W_BLOCKS + bx.
  - `blk_cur_base` = base_cur + idx*CUR_BLK_BYTES.
  - `blk_ref_base` = base_ref + idx*REF_BLK_BYTES.
- Timeout: the timer counts in ARM and RUN. When it reaches TIMEOUT_CYCLES:
  - set `timeout_err` and drop `me_en`;
  - push nothing and abandon the rest of the frame;
  - go to DONE, so `done` still pulses.
- Only one block is ever in flight. Because LAUNCH gates on FIFO space, a push in RUN never meets a full FIFO.
- Result FIFO:
  - pop on `res_valid & res_ready`;
  - a simultaneous push and pop leaves the count unchanged;
  - the outputs show the head entry, and `res_*` data is stable while `res_valid & !res_ready`.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `me_en`, `timeout_err`, `res_valid` = 0;
  - all address outputs and `res_*` data = 0;
  - FIFO empty, bx=by=0.
- `start` sampled in cycle T puts the FSM in LAUNCH at T+1, with `me_en`=1 registered from T+2 if there is space.
- Capture: a rising `me_data_valid` in cycle C gives `res_valid`=1 at C+1 if the FIFO was empty, and `me_en`=0 at C+1.
- `blk_*_base` are registered and valid from LAUNCH onward. They are held constant until NEXT.
- `rst` mid-frame returns to IDLE in the next cycle and discards FIFO contents. `me_en` is low immediately after the reset cycle.

## Structure
- Shared package `me_pkg`:
  - FSM state enum;
  - block-coordinate width (5);
  - result record {sad, mv_col, mv_row, blk_x, blk_y};
  - default stride constants.
- Sub-module `me_result_fifo`: synchronous FIFO parameterised by width and depth, with push/pop/count/full/empty.
- All other logic lives in `me_block_scheduler`.

## Test plan
- 2x2 frame, `frame_base_cur`=0x1000, `frame_base_ref`=0x8000, `res_ready`=1, model core returning MSAD=k+5 for block k -> `blk_cur_base` takes 0x1000/0x1040/0x1080/0x10C0, four results in order with (blk_x, blk_y) = (0,0),(1,0),(0,1),(1,1), a single `done` pulse.
- `res_ready`=0 throughout, 3x3 frame, RES_DEPTH=4 -> exactly 4 results queued and the FSM stalls in LAUNCH with `me_en`=0. Releasing `res_ready` drains the FIFO and completes all 9 blocks in order.
- Model core never raises `me_data_valid` -> after TIMEOUT_CYCLES `timeout_err`=1, `done` pulses, nothing is pushed. The next `start` clears `timeout_err`.
- `start` pulsed during RUN -> ignored, and the block sequence is unchanged.
- `rst` asserted while in RUN with 2 results queued -> next cycle IDLE, `res_valid`=0, `me_en`=0.
- Simultaneous push and pop with the FIFO holding 1 entry -> count stays 1 and ordering is preserved.

Source files
------------

// File: rtl/me_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// me_pkg : shared types and constants for the ME block scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
package me_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ARM    = 3'd2,
        ST_RUN    = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int BLK_COORD_W       = 5;
    localparam int SAD_MAX_W         = 16;
    localparam int DEF_CUR_BLK_BYTES = 64;
    localparam int DEF_REF_BLK_BYTES = 512;

    // SAD field is sized for the widest supported core; narrower MSADs zero-extend.
    typedef struct packed {
        logic [SAD_MAX_W-1:0]   sad;
        logic [BLK_COORD_W-1:0] mv_col;
        logic [BLK_COORD_W-1:0] mv_row;
        logic [BLK_COORD_W-1:0] blk_x;
        logic [BLK_COORD_W-1:0] blk_y;
    } res_rec_t;

endpackage
`default_nettype wire

// File: rtl/me_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// me_result_fifo : synchronous FIFO, head entry shown on data_o (DEPTH >= 2,
//                  power of two)
// Revision: 1.0
// ----------------------------------------------------------------------------
module me_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    // Zero when empty so the reset value of the result outputs is all-zero.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/me_block_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// me_block_scheduler : walks every 8x8 block of a frame through the ME core
//                      and queues each block's MSAD / motion vector
// Revision: 1.0
// ----------------------------------------------------------------------------
module me_block_scheduler
    import me_pkg::*;
#(
    parameter int FRAME_W_BLOCKS = 8,
    parameter int FRAME_H_BLOCKS = 8,
    parameter int CUR_BLK_BYTES  = DEF_CUR_BLK_BYTES,
    parameter int REF_BLK_BYTES  = DEF_REF_BLK_BYTES,
    parameter int SAD_BIT_WIDTH  = 14,
    parameter int RES_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              frame_base_cur,
    input  logic [31:0]              frame_base_ref,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic                     me_en,
    output logic [31:0]              blk_cur_base,
    output logic [31:0]              blk_ref_base,
    input  logic                     me_data_valid,
    input  logic [SAD_BIT_WIDTH-1:0] me_msad,
    input  logic [4:0]               me_col,
    input  logic [4:0]               me_row,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SAD_BIT_WIDTH-1:0] res_sad,
    output logic [4:0]               res_mv_col,
    output logic [4:0]               res_mv_row,
    output logic [4:0]               res_blk_x,
    output logic [4:0]               res_blk_y
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam logic [BLK_COORD_W-1:0] LAST_X    = BLK_COORD_W'(FRAME_W_BLOCKS - 1);
    localparam logic [BLK_COORD_W-1:0] LAST_Y    = BLK_COORD_W'(FRAME_H_BLOCKS - 1);
    localparam logic [TMR_W-1:0]       TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [BLK_COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [31:0]            base_cur_q, base_cur_d, base_ref_q, base_ref_d;
    logic [31:0]            cur_addr_q, cur_addr_d, ref_addr_q, ref_addr_d;
    logic [31:0]            w_idx;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   me_en_q, me_en_d, tmo_q, tmo_d;
    logic                   w_push, w_pop, w_full, w_empty, w_space;
    logic [CNT_W-1:0]       w_count;
    res_rec_t               w_push_rec, w_head;

    assign w_space = (w_count < CNT_W'(RES_DEPTH));

    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        base_cur_d = base_cur_q;
        base_ref_d = base_ref_q;
        timer_d    = timer_q;
        me_en_d    = me_en_q;
        tmo_d      = tmo_q;
        w_push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_cur_d = frame_base_cur;
                    base_ref_d = frame_base_ref;
                    bx_d       = '0;
                    by_d       = '0;
                    tmo_d      = 1'b0;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                me_en_d = 1'b0;
                if (w_space) begin
                    me_en_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM, ST_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == TMR_LIMIT) begin
                    tmo_d   = 1'b1;
                    me_en_d = 1'b0;
                    state_d = ST_DONE;
                end else if (state_q == ST_ARM) begin
                    // data_valid falling is the core's acknowledgement of the launch
                    if (!me_data_valid) state_d = ST_RUN;
                end else if (me_data_valid) begin
                    w_push  = 1'b1;
                    me_en_d = 1'b0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                me_en_d = 1'b0;
                if (bx_q == LAST_X && by_q == LAST_Y) begin
                    state_d = ST_DONE;
                end else begin
                    if (bx_q == LAST_X) begin
                        bx_d = '0;
                        by_d = by_q + BLK_COORD_W'(1);
                    end else begin
                        bx_d = bx_q + BLK_COORD_W'(1);
                    end
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses track the next-state block so they are already valid on entry to LAUNCH.
    assign w_idx      = 32'(by_d) * 32'(FRAME_W_BLOCKS) + 32'(bx_d);
    assign cur_addr_d = base_cur_d + w_idx * 32'(CUR_BLK_BYTES);
    assign ref_addr_d = base_ref_d + w_idx * 32'(REF_BLK_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bx_q       <= '0;
            by_q       <= '0;
            base_cur_q <= '0;
            base_ref_q <= '0;
            cur_addr_q <= '0;
            ref_addr_q <= '0;
            timer_q    <= '0;
            me_en_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            base_cur_q <= base_cur_d;
            base_ref_q <= base_ref_d;
            cur_addr_q <= cur_addr_d;
            ref_addr_q <= ref_addr_d;
            timer_q    <= timer_d;
            me_en_q    <= me_en_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        w_push_rec        = '0;
        w_push_rec.sad    = SAD_MAX_W'(me_msad);
        w_push_rec.mv_col = me_col;
        w_push_rec.mv_row = me_row;
        w_push_rec.blk_x  = bx_q;
        w_push_rec.blk_y  = by_q;
    end

    assign w_pop = !w_empty && res_ready;

    me_result_fifo #(
        .WIDTH ($bits(res_rec_t)),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push && !w_full),
        .data_i  (w_push_rec),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign timeout_err  = tmo_q;
    assign me_en        = me_en_q;
    assign blk_cur_base = cur_addr_q;
    assign blk_ref_base = ref_addr_q;
    assign res_valid    = !w_empty;
    assign res_sad      = w_head.sad[SAD_BIT_WIDTH-1:0];
    assign res_mv_col   = w_head.mv_col;
    assign res_mv_row   = w_head.mv_row;
    assign res_blk_x    = w_head.blk_x;
    assign res_blk_y    = w_head.blk_y;

endmodule
`default_nettype wire

// File: tb/tb_me_block_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_me_block_scheduler : 3x3-frame bench with a behavioural ME core model,
//                         a randomized consumer and a result scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_me_block_scheduler;
    localparam int W     = 3;
    localparam int H     = 3;
    localparam int NB    = W * H;
    localparam int DEPTH = 4;
    localparam int TMO   = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] frame_base_cur = '0;
    logic [31:0] frame_base_ref = '0;
    logic        busy, done, timeout_err, me_en;
    logic [31:0] blk_cur_base, blk_ref_base;
    logic        me_data_valid = 1'b1;
    logic [13:0] me_msad = '0;
    logic [4:0]  me_col = '0;
    logic [4:0]  me_row = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [13:0] res_sad;
    logic [4:0]  res_mv_col, res_mv_row, res_blk_x, res_blk_y;

    me_block_scheduler #(
        .FRAME_W_BLOCKS (W),
        .FRAME_H_BLOCKS (H),
        .CUR_BLK_BYTES  (64),
        .REF_BLK_BYTES  (512),
        .SAD_BIT_WIDTH  (14),
        .RES_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .frame_base_cur (frame_base_cur),
        .frame_base_ref (frame_base_ref),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .me_en          (me_en),
        .blk_cur_base   (blk_cur_base),
        .blk_ref_base   (blk_ref_base),
        .me_data_valid  (me_data_valid),
        .me_msad        (me_msad),
        .me_col         (me_col),
        .me_row         (me_row),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_sad        (res_sad),
        .res_mv_col     (res_mv_col),
        .res_mv_row     (res_mv_row),
        .res_blk_x      (res_blk_x),
        .res_blk_y      (res_blk_y)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural ME core ----------------
    typedef struct {
        bit [13:0] sad;
        bit [4:0]  col;
        bit [4:0]  row;
        bit [4:0]  bx;
        bit [4:0]  by;
    } rec_t;

    rec_t        core_q[$];
    int          cphase = 0;
    int          cdel = 0;
    int          core_launch = 0;
    int          cur_k = 0;
    int          frame_k0 = 0;
    bit          hang = 1'b0;
    bit          sad_rand = 1'b0;
    logic [31:0] exp_cur_base = '0;
    logic [31:0] exp_ref_base = '0;
    rec_t        crec;

    always @(negedge clk) begin
        if (rst) begin
            me_data_valid = 1'b1;
            cphase = 0;
            core_q.delete();
        end else begin
            case (cphase)
                0: if (me_en) begin
                    cur_k = core_launch - frame_k0;
                    chk("cur_base", blk_cur_base, 32'(exp_cur_base + 32'(cur_k) * 32'd64));
                    chk("ref_base", blk_ref_base, 32'(exp_ref_base + 32'(cur_k) * 32'd512));
                    core_launch++;
                    cdel = $urandom_range(0, 2);
                    cphase = 1;
                end
                1: if (!me_en) begin
                    me_data_valid = 1'b1;
                    cphase = 0;
                end else if (cdel == 0) begin
                    me_data_valid = 1'b0;
                    cdel = $urandom_range(1, 8);
                    cphase = 2;
                end else begin
                    cdel--;
                end
                2: if (!me_en) begin
                    me_data_valid = 1'b1;
                    cphase = 0;
                end else if (!hang) begin
                    if (cdel == 0) begin
                        crec.sad = sad_rand ? 14'($urandom) : 14'(cur_k + 5);
                        crec.col = 5'($urandom);
                        crec.row = 5'($urandom);
                        crec.bx  = 5'(cur_k % W);
                        crec.by  = 5'(cur_k / W);
                        core_q.push_back(crec);
                        me_msad = crec.sad;
                        me_col  = crec.col;
                        me_row  = crec.row;
                        me_data_valid = 1'b1;
                        cphase = 3;
                    end else begin
                        cdel--;
                    end
                end
                default: if (!me_en) cphase = 0;
            endcase
        end
    end

    // ---------------- consumer / scoreboard ----------------
    int          ready_mode = 1;
    int          pop_idx = 0;
    int          pops_total = 0;
    bit          hold_prev = 1'b0;
    logic [33:0] held = '0;
    logic [33:0] exp_rec;

    always @(negedge clk) begin
        if (rst) begin
            pop_idx = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", {res_sad, res_mv_col, res_mv_row, res_blk_x, res_blk_y}, held);
            end
            case (ready_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (res_valid && res_ready) begin
                if (pop_idx < core_q.size()) begin
                    exp_rec = {core_q[pop_idx].sad, core_q[pop_idx].col, core_q[pop_idx].row,
                               core_q[pop_idx].bx, core_q[pop_idx].by};
                    chk("result", {res_sad, res_mv_col, res_mv_row, res_blk_x, res_blk_y}, exp_rec);
                end else begin
                    chk("pop_underrun", pop_idx, core_q.size());
                end
                pop_idx++;
                pops_total++;
            end
            hold_prev = res_valid && !res_ready;
            held = {res_sad, res_mv_col, res_mv_row, res_blk_x, res_blk_y};
        end
    end

    int done_cnt = 0;
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            chk("done_width", done_prev, 0);
        end
        done_prev = done;
    end

    // ---------------- frame helpers ----------------
    int p0 = 0;
    int d0 = 0;

    task automatic launch(input logic [31:0] bc, input logic [31:0] br);
        exp_cur_base   = bc;
        exp_ref_base   = br;
        frame_k0       = core_launch;
        p0             = pops_total;
        d0             = done_cnt;
        frame_base_cur = bc;
        frame_base_ref = br;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("tmo_cleared", timeout_err, 0);
    endtask

    task automatic finish_frame(input int exp_n, input bit exp_tmo, output int cyc);
        int dr;
        cyc = 0;
        while (!done && cyc < 5000) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_wait_expired", done, 1);
        dr = 0;
        while ((busy || res_valid) && dr < 300) begin
            tick();
            dr++;
        end
        if (busy || res_valid) chk("drain_wait_expired", res_valid, 0);
        repeat (2) tick();
        chk("n_results", pops_total - p0, exp_n);
        chk("n_done", done_cnt - d0, 1);
        chk("timeout_flag", timeout_err, exp_tmo);
        chk("busy_end", busy, 0);
    endtask

    task automatic wait_k(input int target);
        int c;
        c = 0;
        while (!((core_launch - frame_k0) >= target && cphase == 2) && c < 1000) begin
            tick();
            c++;
        end
        if (c >= 1000) chk("wait_k_expired", core_launch - frame_k0, target);
    endtask

    typedef struct {
        logic [31:0] bc;
        logic [31:0] br;
        int          rmode;
        bit          hng;
        bit          srand;
        int          exp_n;
        bit          exp_tmo;
    } vec_t;

    vec_t tbl[5];
    int   cyc;

    initial begin
        tbl[0] = '{32'h0000_1000, 32'h0000_8000, 1, 1'b0, 1'b0, NB, 1'b0};
        tbl[1] = '{32'h0002_0000, 32'h0040_0000, 2, 1'b0, 1'b1, NB, 1'b0};
        tbl[2] = '{32'hFFFF_FF80, 32'hFFFF_F000, 2, 1'b0, 1'b1, NB, 1'b0};
        tbl[3] = '{32'h0000_3000, 32'h0000_9000, 1, 1'b1, 1'b0, 0,  1'b1};
        tbl[4] = '{32'h0000_1000, 32'h0000_8000, 2, 1'b0, 1'b1, NB, 1'b0};

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_me_en", me_en, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cur_base", blk_cur_base, 0);
        chk("rst_ref_base", blk_ref_base, 0);
        chk("rst_res_data", {res_sad, res_mv_col, res_mv_row, res_blk_x, res_blk_y}, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            ready_mode = tbl[i].rmode;
            hang       = tbl[i].hng;
            sad_rand   = tbl[i].srand;
            launch(tbl[i].bc, tbl[i].br);
            finish_frame(tbl[i].exp_n, tbl[i].exp_tmo, cyc);
            if (tbl[i].exp_tmo)
                chk("tmo_latency_in_range", (cyc >= TMO) && (cyc <= TMO + 8), 1);
        end
        hang = 1'b0;

        // Consumer stalled: FIFO fills and the scheduler parks with me_en low.
        ready_mode = 0;
        sad_rand = 1'b1;
        launch(32'h0000_5000, 32'h000A_0000);
        repeat (200) tick();
        chk("stall_launches", core_launch - frame_k0, DEPTH);
        chk("stall_me_en", me_en, 0);
        chk("stall_busy", busy, 1);
        chk("stall_res_valid", res_valid, 1);
        chk("stall_no_pops", pops_total - p0, 0);
        ready_mode = 1;
        finish_frame(NB, 1'b0, cyc);
        chk("stall_all_launched", core_launch - frame_k0, NB);

        // Stray start mid-block must not relatch bases or restart the walk.
        ready_mode = 2;
        launch(32'h0000_1000, 32'h0000_8000);
        wait_k(5);
        frame_base_cur = 32'hDEAD_0000;
        frame_base_ref = 32'hBEEF_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame(NB, 1'b0, cyc);
        chk("stray_start_launches", core_launch - frame_k0, NB);

        // Reset with two results queued and the third block running.
        ready_mode = 0;
        launch(32'h0000_2000, 32'h0000_4000);
        wait_k(3);
        chk("pre_rst_res_valid", res_valid, 1);
        chk("pre_rst_me_en", me_en, 1);
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_res_valid", res_valid, 0);
        chk("post_rst_me_en", me_en, 0);
        tick();
        rst = 1'b0;
        ready_mode = 1;
        repeat (3) tick();
        chk("post_rst_idle_valid", res_valid, 0);
        launch(32'h0000_1000, 32'h0000_8000);
        finish_frame(NB, 1'b0, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
